// File: rtl/sr_packet_splitter_if.sv
// Packet-in / flit-out bundle for sr_packet_splitter.
// master = packet source and NoC side; slave = the splitter.
interface sr_packet_splitter_if #(
  parameter int NODE_COUNT      = 8,
  parameter int PACKET_ID_WIDTH = 5
);
  logic [67:0]                     packetIn;
  logic [$clog2(NODE_COUNT)-1:0]   nodeDest;
  logic [PACKET_ID_WIDTH-1:0]      packetId;
  logic                            validIn;
  logic                            splitterReady;
  logic [33:0]                     flitOut;
  logic                            flitValid;
  logic                            flitReady;
  logic                            overflow;

  modport master (
    output packetIn, nodeDest, packetId, validIn, flitReady,
    input  splitterReady, flitOut, flitValid, overflow
  );

  modport slave (
    input  packetIn, nodeDest, packetId, validIn, flitReady,
    output splitterReady, flitOut, flitValid, overflow
  );
endinterface

// File: rtl/sr_packet_splitter.sv
// Buffers 68-bit packets and emits them as head/body/tail NoC flits.
// Define SR_SPLITTER_CHECKSUM_EN to append an XOR checksum tail flit.
module sr_packet_splitter #(
  parameter int NODE_ID         = 0,
  parameter int NODE_COUNT      = 8,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int FIFO_DEPTH      = 2
) (
  input logic               clk,
  input logic               rst,
  sr_packet_splitter_if.slave bus
);
  localparam int DEST_W = $clog2(NODE_COUNT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
`ifdef SR_SPLITTER_CHECKSUM_EN
  localparam logic [3:0] FLIT_TOTAL = 4'd5;
`else
  localparam logic [3:0] FLIT_TOTAL = 4'd4;
`endif

  typedef enum logic [2:0] {
    IDLE, HEAD, BODY0, BODY1, BODY2
`ifdef SR_SPLITTER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  logic [67:0]                pktMem  [FIFO_DEPTH];
  logic [DEST_W-1:0]          destMem [FIFO_DEPTH];
  logic [PACKET_ID_WIDTH-1:0] idMem   [FIFO_DEPTH];

  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] count, countNext;
  logic             push, pop, flitHs, lastFlit, overflowQ;
  state_t           state, stateNext;

  logic [67:0] headPkt;
  logic [31:0] body0, body1, body2;

  assign bus.splitterReady = (count != CNT_W'(FIFO_DEPTH));
  assign bus.flitValid     = (state != IDLE);
  assign bus.overflow      = overflowQ;

  assign push   = bus.validIn && bus.splitterReady;
  assign flitHs = bus.flitValid && bus.flitReady;
`ifdef SR_SPLITTER_CHECKSUM_EN
  assign lastFlit = (state == CSUM);
`else
  assign lastFlit = (state == BODY2);
`endif
  assign pop = flitHs && lastFlit;

  always_comb begin
    countNext = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      overflowQ <= 1'b0;
      state     <= IDLE;
    end else begin
      if (push) begin
        pktMem[wrPtr]  <= bus.packetIn;
        destMem[wrPtr] <= bus.nodeDest;
        idMem[wrPtr]   <= bus.packetId;
        wrPtr          <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= countNext;
      if (bus.validIn && !bus.splitterReady) overflowQ <= 1'b1;
      state <= stateNext;
    end
  end

  // Count after the pop (including a same-cycle push) picks HEAD vs IDLE,
  // so back-to-back packets leave no idle gap.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (count != '0) stateNext = HEAD;
      HEAD:  if (flitHs) stateNext = BODY0;
      BODY0: if (flitHs) stateNext = BODY1;
      BODY1: if (flitHs) stateNext = BODY2;
`ifdef SR_SPLITTER_CHECKSUM_EN
      BODY2: if (flitHs) stateNext = CSUM;
      CSUM:  if (flitHs) stateNext = (countNext != '0) ? HEAD : IDLE;
`else
      BODY2: if (flitHs) stateNext = (countNext != '0) ? HEAD : IDLE;
`endif
      default: stateNext = IDLE;
    endcase
  end

  assign headPkt = pktMem[rdPtr];
  assign body0   = headPkt[31:0];
  assign body1   = headPkt[63:32];
  assign body2   = {28'b0, headPkt[67:64]};

  always_comb begin
    bus.flitOut = '0;
    case (state)
      HEAD:  bus.flitOut = {2'b01, FLIT_TOTAL, 12'(idMem[rdPtr]), 8'(NODE_ID), 8'(destMem[rdPtr])};
      BODY0: bus.flitOut = {2'b00, body0};
      BODY1: bus.flitOut = {2'b00, body1};
`ifdef SR_SPLITTER_CHECKSUM_EN
      BODY2: bus.flitOut = {2'b00, body2};
      CSUM:  bus.flitOut = {2'b10, body0 ^ body1 ^ body2};
`else
      BODY2: bus.flitOut = {2'b10, body2};
`endif
      default: bus.flitOut = '0;
    endcase
  end
endmodule

// File: tb/tb_sr_packet_splitter.sv
// Self-checking bench for sr_packet_splitter: vector table plus scoreboard
// of expected flits, and directed stall/overflow/reset/back-to-back sequences.
module tb_sr_packet_splitter;
`ifdef SR_SPLITTER_CHECKSUM_EN
  localparam logic [3:0] FLITS = 4'd5;
`else
  localparam logic [3:0] FLITS = 4'd4;
`endif
  localparam int NFLITS = int'(FLITS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr_packet_splitter_if #(.NODE_COUNT(8), .PACKET_ID_WIDTH(5)) bus ();

  sr_packet_splitter #(
    .NODE_ID(2), .NODE_COUNT(8), .PACKET_ID_WIDTH(5), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [67:0] pkt;
    logic [2:0]  dest;
    logic [4:0]  id;
    logic [27:0] expLow;   // expected head bits [27:0] with NODE_ID=2
  } vec_t;
  vec_t vecs[5];

  logic [33:0] expQ[$];
  int checks = 0;
  int failures = 0;
  int runLen = 0;
  int maxRun = 0;
  bit monEn = 1'b0;
  bit randReady = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic queuePacket(input logic [67:0] p, input logic [27:0] low);
    logic [31:0] b2;
    b2 = {28'b0, p[67:64]};
    expQ.push_back({2'b01, FLITS, low});
    expQ.push_back({2'b00, p[31:0]});
    expQ.push_back({2'b00, p[63:32]});
`ifdef SR_SPLITTER_CHECKSUM_EN
    expQ.push_back({2'b00, b2});
    expQ.push_back({2'b10, p[31:0] ^ p[63:32] ^ b2});
`else
    expQ.push_back({2'b10, b2});
`endif
  endtask

  // Drive one packet strobe for one cycle; expAcc says whether it must be taken.
  task automatic sendPkt(input int i, input logic expAcc);
    bus.packetIn = vecs[i].pkt;
    bus.nodeDest = vecs[i].dest;
    bus.packetId = vecs[i].id;
    bus.validIn  = 1'b1;
    check("splitterReady_at_push", bus.splitterReady, expAcc);
    if (expAcc) queuePacket(vecs[i].pkt, vecs[i].expLow);
    @(posedge clk); #1;
    bus.validIn = 1'b0;
  endtask

  task automatic waitQ(input int n, input string name);
    int k;
    k = 0;
    while (expQ.size() != n && k < 80) begin
      @(posedge clk); #1;
      k++;
      if (randReady) bus.flitReady = 1'($urandom_range(0, 1));
    end
    check(name, expQ.size(), n);
  endtask

  task automatic drain(input string name);
    waitQ(0, name);
    @(posedge clk); #1;
    check("idle_after_drain", bus.flitValid, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    expQ.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (monEn && !rst) begin
      if (bus.flitValid) begin
        runLen++;
        if (expQ.size() == 0)
          check("spurious_flitValid", bus.flitValid, 1'b0);
        else if (bus.flitReady)
          check("flit", bus.flitOut, expQ.pop_front());
        else
          check("stall_flit", bus.flitOut, expQ[0]);
      end else begin
        if (runLen > maxRun) maxRun = runLen;
        runLen = 0;
        check("idle_flitOut_zero", bus.flitOut, 34'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{{1'b0, 32'hAAAAAAAA, 32'h00000010, 3'h1}, 3'd3, 5'd7,  28'h0070203};
    vecs[1] = '{68'hF_1234_5678_9ABC_DEF0,                3'd7, 5'd31, 28'h01F0207};
    vecs[2] = '{68'h0,                                    3'd0, 5'd0,  28'h0000200};
    vecs[3] = '{68'h8_0000_0001_8000_0000,                3'd5, 5'd16, 28'h0100205};
    vecs[4] = '{68'h5_A5A5_A5A5_5A5A_5A5A,                3'd1, 5'd1,  28'h0010201};

    // Reset, with a strobe held during reset that must be ignored.
    rst = 1'b1;
    bus.packetIn = vecs[0].pkt;
    bus.nodeDest = vecs[0].dest;
    bus.packetId = vecs[0].id;
    bus.validIn = 1'b1;
    bus.flitReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.validIn = 1'b0;
    rst = 1'b0;
    check("rst_flitValid", bus.flitValid, 1'b0);
    check("rst_flitOut", bus.flitOut, 34'h0);
    check("rst_splitterReady", bus.splitterReady, 1'b1);
    check("rst_overflow", bus.overflow, 1'b0);
    @(posedge clk); #1;
    check("reset_strobe_ignored", bus.flitValid, 1'b0);
    monEn = 1'b1;

    // Vector table; odd entries use random flitReady backpressure.
    for (int i = 0; i < 5; i++) begin
      bus.flitReady = 1'b1;
      randReady = (i % 2 == 1);
      sendPkt(i, 1'b1);
      drain("table_drain");
      randReady = 1'b0;
      bus.flitReady = 1'b1;
    end

    // Stall for 5 cycles while BODY1 is presented.
    sendPkt(3, 1'b1);
    waitQ(NFLITS - 2, "reach_body1");
    bus.flitReady = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stall_valid_held", bus.flitValid, 1'b1);
    bus.flitReady = 1'b1;
    drain("stall_drain");

    // Two queued packets stream with no gap.
    maxRun = 0;
    sendPkt(0, 1'b1);
    sendPkt(1, 1'b1);
    drain("b2b_drain");
    @(negedge clk); #1;
    check("b2b_consecutive_flits", maxRun, 2 * NFLITS);

    // Push refused while full, even on the cycle the tail pops.
    sendPkt(2, 1'b1);
    sendPkt(4, 1'b1);
    waitQ(NFLITS + 1, "reach_tail_full");
    sendPkt(1, 1'b0);
    check("overflow_on_full_tail", bus.overflow, 1'b1);
    drain("full_tail_drain");
    doReset();
    check("overflow_cleared", bus.overflow, 1'b0);

    // Push coinciding with the tail pop at count=1.
    sendPkt(3, 1'b1);
    waitQ(1, "reach_tail_single");
    sendPkt(4, 1'b1);
    check("pushpop_next_head_valid", bus.flitValid, 1'b1);
    check("pushpop_count_one_ready", bus.splitterReady, 1'b1);
    drain("pushpop_drain");

    // Reset mid-packet (BODY0) abandons it; a new packet restarts at HEAD.
    sendPkt(1, 1'b1);
    waitQ(NFLITS - 1, "reach_body0");
    rst = 1'b1;
    bus.validIn = 1'b1;
    expQ.delete();
    @(posedge clk); #1;
    check("midrst_flitValid", bus.flitValid, 1'b0);
    check("midrst_splitterReady", bus.splitterReady, 1'b1);
    check("midrst_flitOut", bus.flitOut, 34'h0);
    rst = 1'b0;
    bus.validIn = 1'b0;
    @(posedge clk); #1;
    check("midrst_stays_idle", bus.flitValid, 1'b0);
    sendPkt(0, 1'b1);
    drain("after_rst_drain");

    // Three strobes into a stalled depth-2 FIFO: third is dropped.
    bus.flitReady = 1'b0;
    sendPkt(0, 1'b1);
    sendPkt(1, 1'b1);
    check("ovf_before_drop", bus.overflow, 1'b0);
    sendPkt(2, 1'b0);
    check("ovf_after_drop", bus.overflow, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    bus.flitReady = 1'b1;
    drain("ovf_drain");
    check("ovf_sticky", bus.overflow, 1'b1);
    doReset();
    check("ovf_rst_clear", bus.overflow, 1'b0);

    monEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
